sha256_stream_core: RTL

SHA256_STREAM_CORE -- requirements
Module: sha256_stream_core

---
 rtl/sha256_stream_core.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/sha256_stream_core.sv
// sha256_stream_core: streaming SHA-256 / SHA-224 compression core.
//   Takes pre-padded 512-bit blocks as sixteen 32-bit big-endian words. It runs
//   one round per cycle and streams the digest out in OUT_WIDTH-bit beats,
//   starting with the MSB of H0.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready input word handshake; in_data word, in_last ends message
//   mode_224          1 = SHA-224 (sampled on the first word of a message)
//   out_valid/out_ready digest beat handshake; out_data beat, out_last final beat
//   busy              high whenever the FSM is not in IDLE
//   state_o           current FSM state (debug visibility)
// Handshakes: a word moves when in_valid && in_ready, and a beat moves when
// out_valid && out_ready. The sender may change its payload only after a
// transfer. out_data/out_last hold steady while a beat is stalled.
module sha256_stream_core #(
  parameter int OUT_WIDTH = 8,
  parameter bit SHA224_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_data,
  input  logic                 in_last,
  input  logic                 mode_224,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ROUND, S_UPDATE, S_SEND} state_e;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IV256 [8] = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] IV224 [8] = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                                        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
  localparam logic [5:0] LAST256 = 6'(256 / OUT_WIDTH - 1);
  localparam logic [5:0] LAST224 = 6'(224 / OUT_WIDTH - 1);

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  cnt_q;        // next word slot to fill in LOAD
  logic [5:0]  rnd_q;        // round index t in ROUND
  logic [5:0]  beat_q;       // digest beat index in SEND
  logic        last_q;       // in_last captured with word 15
  logic        m224_q;       // mode latched for the whole message
  logic [31:0] h_q [8];
  logic [31:0] v_q [8];      // working variables a..h
  logic [31:0] w_q [16];     // w_q[i] holds W[t+i] during round t

  logic        in_accept, sel224;
  logic [31:0] t1, t2, w_next;
  logic [255:0] digest, digest_sh;
  logic [8:0]  bit_off;

  assign in_accept = in_valid && in_ready;
  assign sel224    = mode_224 && SHA224_EN;

  assign t1 = v_q[7] + (rotr(v_q[4], 6) ^ rotr(v_q[4], 11) ^ rotr(v_q[4], 25))
            + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + K_ROM[rnd_q] + w_q[0];
  assign t2 = (rotr(v_q[0], 2) ^ rotr(v_q[0], 13) ^ rotr(v_q[0], 22))
            + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
  // Schedule word W[t+16], which enters the top of the window during round t.
  assign w_next = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
                + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];

  assign digest    = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};
  assign bit_off   = 9'(beat_q) * 9'(OUT_WIDTH);
  assign digest_sh = digest << bit_off;
  assign state_o   = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    busy      = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = S_LOAD;
      end
      S_LOAD: begin
        in_ready = 1'b1;
        if (in_valid && cnt_q == 4'd15) state_d = S_ROUND;
      end
      S_ROUND:  if (rnd_q == 6'd63) state_d = S_UPDATE;
      S_UPDATE: state_d = last_q ? S_SEND : S_LOAD;
      S_SEND: begin
        out_valid = 1'b1;
        out_data  = digest_sh[255 -: OUT_WIDTH];
        out_last  = (beat_q == (m224_q ? LAST224 : LAST256));
        if (out_ready && out_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rnd_q  <= '0;
      beat_q <= '0;
      last_q <= 1'b0;
      m224_q <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        h_q[i] <= '0;
        v_q[i] <= '0;
      end
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (in_accept) begin
          for (int i = 0; i < 8; i++) begin
            h_q[i] <= sel224 ? IV224[i] : IV256[i];
            v_q[i] <= sel224 ? IV224[i] : IV256[i];
          end
          m224_q <= sel224;
          w_q[0] <= in_data;
          cnt_q  <= 4'd1;
        end
        S_LOAD: if (in_accept) begin
          w_q[cnt_q] <= in_data;
          cnt_q      <= cnt_q + 4'd1;   // wraps to 0 after word 15
          if (cnt_q == 4'd15) begin
            last_q <= in_last;
            rnd_q  <= '0;
          end
        end
        S_ROUND: begin
          v_q[0] <= t1 + t2;
          v_q[1] <= v_q[0];
          v_q[2] <= v_q[1];
          v_q[3] <= v_q[2];
          v_q[4] <= v_q[3] + t1;
          v_q[5] <= v_q[4];
          v_q[6] <= v_q[5];
          v_q[7] <= v_q[6];
          for (int i = 0; i < 15; i++) w_q[i] <= w_q[i + 1];
          w_q[15] <= w_next;
          rnd_q   <= rnd_q + 6'd1;
        end
        S_UPDATE: begin
          for (int i = 0; i < 8; i++) begin
            h_q[i] <= h_q[i] + v_q[i];
            v_q[i] <= h_q[i] + v_q[i];
          end
          cnt_q  <= '0;
          beat_q <= '0;
        end
        S_SEND: if (out_ready) beat_q <= out_last ? 6'd0 : beat_q + 6'd1;
        default: ;
      endcase
    end
  end

endmodule
